bn_para_bank_loader: RTL and testbench
======================================

# bn_para_bank_loader

Double-buffered, parametrised loader for per-layer rsign, batch-norm and activation parameters in the ResNet layer pipeline. It accepts a serial stream of signed parameter words through a valid/ready handshake and writes them into a shadow bank. On a commit it copies the shadow bank to the active bank that drives the datapath. This lets the next layer's parameters load while the current layer computes. Over the single-bank loader it adds backpressure, a generic parameter count, a completion flag, restart and commit-error reporting.

## Interface
- PARA_WIDTH, 16, bit width of each signed parameter word
- CHANNEL_NUM, 128, entries for parameter types 1..PARA_NUM-1
- FIRST_DEPTH, 64, entries for parameter type 0 (rsign); must be 1..CHANNEL_NUM
- PARA_NUM, 6, number of parameter types; must be ≥2
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- mode_in  input  1  0 = load mode (words may be accepted), 1 = compute mode (no accept)
- in_valid  input  1  para_in holds a word
- in_ready  output  1  loader can accept a word this cycle
- para_in  input  PARA_WIDTH signed  parameter word
- restart  input  1  one-cycle pulse: abandon the current load and begin again at type 0, index 0
- swap  input  1  one-cycle pulse: commit the shadow bank to the active bank
- para_out  output  signed PARA_WIDTH × [PARA_NUM][CHANNEL_NUM]  active bank; type 0 entries ≥ FIRST_DEPTH are always 0
- load_done  output  1  shadow bank is completely loaded and awaiting swap
- swap_err  output  1  one-cycle pulse: swap arrived while state ≠ FULL

## Operation
- Stream order: type 0 indices 0..FIRST_DEPTH-1, then type 1 indices 0..CHANNEL_NUM-1, up to type PARA_NUM-1. Total words N = FIRST_DEPTH + (PARA_NUM-1)·CHANNEL_NUM (704 at defaults).
- Counters: type cnt_t, width $clog2(PARA_NUM); index cnt_i, width $clog2(CHANNEL_NUM).
- Accept condition: in_valid && in_ready. Combinational in_ready = (state==LOAD) && !mode_in && !restart.
- On accept: write shadow[cnt_t][cnt_i] <= para_in, then advance the counters.
  - cnt_i wraps to 0 at FIRST_DEPTH-1 when cnt_t==0, and at CHANNEL_NUM-1 otherwise.
  - cnt_t increments on each wrap.
  - The last word (cnt_t==PARA_NUM-1, cnt_i==CHANNEL_NUM-1) moves the state to FULL and leaves the counters at 0.
- States:
  - LOAD: accepting words. Leaves only on the last word (→ FULL).
  - FULL: in_ready=0, load_done=1.
  - swap in FULL: active <= shadow (all entries, one edge), state → LOAD, counters 0, load_done → 0. The shadow contents are kept and are overwritten by the next load.
  - swap in LOAD: ignored; swap_err pulses for one cycle; active bank unchanged.
- restart, any state: counters → 0, state → LOAD, load_done → 0. Shadow contents are not cleared; a partial load followed by restart then N words yields a fully new shadow. restart takes priority over a simultaneous swap (no commit, no swap_err).
- mode_in=1 stalls acceptance only. Counters hold, and swap/restart still act.
- Signed values pass through unmodified; there is no arithmetic.

## Timing
- Reset (async assert): active and shadow all 0, state LOAD, counters 0, load_done 0, swap_err 0. in_ready then follows mode_in.
- Shadow write and counter update take effect on the accepting edge.
- load_done is registered: high the cycle after the last word is accepted.
- para_out updates on the edge that samples swap and is visible the following cycle. Zero cycles of mixed old/new data.
- swap_err is registered: high exactly one cycle after the offending swap.
- in_valid may drop at any cycle (gaps allowed). para_in is only sampled on accept.
- Reset asserted mid-load: everything returns to reset values, including the active bank. The partial load is lost.

## Test plan
- Full load: words k=0..703, in_valid held high, mode_in=0 → in_ready low from cycle 705. load_done=1. para_out still all 0. swap, then next cycle: para_out[0][63]=63, para_out[0][64]=0, para_out[1][0]=64, para_out[5][127]=703.
- Backpressure/gaps: random in_valid gaps and mode_in=1 windows during the load → exactly 704 accepts. Identical final para_out to the full-load case. No accept while mode_in=1.
- Double-buffering: after the first commit, load words 1000+k. Check para_out unchanged throughout (e.g. [3][5]=325). After the second swap, [3][5]=1325.
- Premature swap: swap after 100 words → swap_err pulse of 1 cycle, para_out unchanged, loading continues to word 704 normally.
- Restart mid-load: 300 words, restart, then N words with value −k → shadow fully replaced. After swap, para_out[0][0]=0, para_out[2][10]=−202. A word offered in the restart cycle is not accepted.
- Async reset at word 400 → all outputs 0 immediately. A subsequent full load and swap behave as in the full-load scenario.

Source files
------------

// File: rtl/bn_para_bank_loader_if.sv
// Parameter-word stream handshake between the parameter source and the bank loader.
interface bn_para_bank_loader_if #(
    parameter int PARA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [PARA_WIDTH-1:0] para_in;

    modport master (output in_valid, output para_in, input in_ready);
    modport slave  (input in_valid, input para_in, output in_ready);
endinterface

// File: rtl/bn_para_bank_loader.sv
// Double-buffered rsign/BN/activation parameter loader: serial words fill a shadow
// bank, and a swap commits the whole shadow bank to the active bank in one edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting words into the shadow bank at (cnt_t, cnt_i)
// FULL  | shadow bank complete; waiting for swap to commit it
module bn_para_bank_loader #(
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int FIRST_DEPTH = 64,
    parameter int PARA_NUM    = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         mode_in,
    input  logic                         restart,
    input  logic                         swap,
    bn_para_bank_loader_if.slave         s_para,
    output logic signed [PARA_WIDTH-1:0] para_out [PARA_NUM][CHANNEL_NUM],
    output logic                         load_done,
    output logic                         swap_err
);
    localparam int TW = (PARA_NUM > 1) ? $clog2(PARA_NUM) : 1;
    localparam int IW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PARA_NUM - 1);
    localparam logic [IW-1:0] I_LAST = IW'(CHANNEL_NUM - 1);
    localparam logic [IW-1:0] F_LAST = IW'(FIRST_DEPTH - 1);

    typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] cnt_t, cnt_t_nxt;
    logic [IW-1:0] cnt_i, cnt_i_nxt;
    logic          accept;
    logic          commit;
    logic          swap_err_nxt;
    logic          wrap;

    logic signed [PARA_WIDTH-1:0] shadow [PARA_NUM][CHANNEL_NUM];

    assign s_para.in_ready = (state == LOAD) && !mode_in && !restart;
    assign accept          = s_para.in_valid && s_para.in_ready;
    assign load_done       = (state == FULL);
    assign wrap            = (cnt_t == '0) ? (cnt_i == F_LAST) : (cnt_i == I_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= LOAD;
            cnt_t    <= '0;
            cnt_i    <= '0;
            swap_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_t    <= cnt_t_nxt;
            cnt_i    <= cnt_i_nxt;
            swap_err <= swap_err_nxt;
        end
    end

    // restart outranks swap, so a restart+swap pair neither commits nor flags an error
    always_comb begin
        state_nxt    = state;
        cnt_t_nxt    = cnt_t;
        cnt_i_nxt    = cnt_i;
        commit       = 1'b0;
        swap_err_nxt = 1'b0;
        if (restart) begin
            state_nxt = LOAD;
            cnt_t_nxt = '0;
            cnt_i_nxt = '0;
        end else begin
            case (state)
                LOAD: begin
                    swap_err_nxt = swap;
                    if (accept) begin
                        if (cnt_t == T_LAST && cnt_i == I_LAST) begin
                            state_nxt = FULL;
                            cnt_t_nxt = '0;
                            cnt_i_nxt = '0;
                        end else if (wrap) begin
                            cnt_t_nxt = cnt_t + TW'(1);
                            cnt_i_nxt = '0;
                        end else begin
                            cnt_i_nxt = cnt_i + IW'(1);
                        end
                    end
                end
                FULL: begin
                    if (swap) begin
                        commit    = 1'b1;
                        state_nxt = LOAD;
                        cnt_t_nxt = '0;
                        cnt_i_nxt = '0;
                    end
                end
                default: state_nxt = LOAD;
            endcase
        end
    end

    // type-0 entries past FIRST_DEPTH are never written, so they stay 0 in both banks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < PARA_NUM; t++)
                for (int i = 0; i < CHANNEL_NUM; i++)
                    shadow[t][i] <= '0;
        end else if (accept) begin
            shadow[cnt_t][cnt_i] <= s_para.para_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < PARA_NUM; t++)
                for (int i = 0; i < CHANNEL_NUM; i++)
                    para_out[t][i] <= '0;
        end else if (commit) begin
            para_out <= shadow;
        end
    end
endmodule

// File: tb/tb_bn_para_bank_loader.sv
// Self-checking bench for bn_para_bank_loader: directed loads, swaps, restarts and resets,
// with a table of hand-computed active-bank samples checked after each commit.
module tb_bn_para_bank_loader;
    localparam int PW = 16;
    localparam int CN = 128;
    localparam int FD = 64;
    localparam int PN = 6;
    localparam int NW = FD + (PN - 1) * CN;

    typedef struct {
        int scen;
        int t;
        int i;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic mode_in = 1'b0;
    logic restart = 1'b0;
    logic swap = 1'b0;
    logic load_done;
    logic swap_err;
    logic signed [PW-1:0] para_out [PN][CN];

    bn_para_bank_loader_if #(.PARA_WIDTH(PW)) p_if ();

    bn_para_bank_loader #(
        .PARA_WIDTH (PW),
        .CHANNEL_NUM(CN),
        .FIRST_DEPTH(FD),
        .PARA_NUM   (PN)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mode_in  (mode_in),
        .restart  (restart),
        .swap     (swap),
        .s_para   (p_if),
        .para_out (para_out),
        .load_done(load_done),
        .swap_err (swap_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_shadow [PN][CN];
    int m_active [PN][CN];
    int mt = 0;
    int mi = 0;
    int stall_viol = 0;
    vec_t vecs [$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cmp_bank(input string name);
        int bad = 0;
        int ft = 0, fi = 0, fg = 0, fe = 0;
        for (int t = 0; t < PN; t++)
            for (int i = 0; i < CN; i++) begin
                int g;
                g = para_out[t][i];
                if (g !== m_active[t][i]) begin
                    if (bad == 0) begin ft = t; fi = i; fg = g; fe = m_active[t][i]; end
                    bad++;
                end
            end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d entries differ, first [%0d][%0d] got %0d expected %0d",
                     name, bad, ft, fi, fg, fe);
        end
    endtask

    task automatic check_table(input int scen);
        foreach (vecs[n])
            if (vecs[n].scen == scen)
                chk($sformatf("para_out_s%0d[%0d][%0d]", scen, vecs[n].t, vecs[n].i),
                    int'(para_out[vecs[n].t][vecs[n].i]), vecs[n].exp);
    endtask

    task automatic model_adv();
        if (mt == 0 && mi == FD - 1) begin
            mi = 0; mt = 1;
        end else if (mt != 0 && mi == CN - 1) begin
            mi = 0; mt = (mt == PN - 1) ? 0 : mt + 1;
        end else begin
            mi++;
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < PN; t++)
            for (int i = 0; i < CN; i++) begin
                m_shadow[t][i] = 0;
                m_active[t][i] = 0;
            end
        mt = 0; mi = 0;
    endtask

    // Offers word values off+sgn*k for k in [k0,k1); entered and left 1ns after a rising edge.
    task automatic load_words(input int k0, input int k1, input int off, input int sgn, input bit gaps);
        int k = k0;
        int cyc = 0;
        bit acc;
        while (k < k1 && cyc < 4000) begin
            p_if.para_in = PW'(off + sgn * k);
            if (gaps) begin
                p_if.in_valid = ($urandom_range(0, 3) != 0);
                mode_in = ((cyc % 50) >= 20 && (cyc % 50) < 27);
            end else begin
                p_if.in_valid = 1'b1;
                mode_in = 1'b0;
            end
            @(negedge clk);
            acc = p_if.in_valid && p_if.in_ready;
            if (mode_in && p_if.in_ready) stall_viol++;
            @(posedge clk);
            if (acc) begin
                m_shadow[mt][mi] = off + sgn * k;
                model_adv();
                k++;
            end
            #1;
            cyc++;
        end
        p_if.in_valid = 1'b0;
        mode_in = 1'b0;
        chk("words_accepted", k, k1);
    endtask

    task automatic do_swap(input bit commit);
        swap = 1'b1;
        @(posedge clk);
        #1;
        swap = 1'b0;
        if (commit) m_active = m_shadow;
    endtask

    task automatic check_full(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready_full"}, int'(p_if.in_ready), 0);
        chk({tag, "_load_done"}, int'(load_done), 1);
        cmp_bank({tag, "_active_before_swap"});
        @(posedge clk);
        #1;
    endtask

    task automatic check_after_swap(input string tag, input int scen);
        @(negedge clk);
        chk({tag, "_load_done_cleared"}, int'(load_done), 0);
        chk({tag, "_in_ready_again"}, int'(p_if.in_ready), 1);
        chk({tag, "_swap_err_quiet"}, int'(swap_err), 0);
        cmp_bank({tag, "_active_after_swap"});
        check_table(scen);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = '{
            '{1, 0, 63, 63}, '{1, 0, 64, 0}, '{1, 1, 0, 64}, '{1, 5, 127, 703},
            '{1, 3, 5, 325}, '{1, 0, 0, 0},
            '{2, 3, 5, 1325}, '{2, 0, 64, 0}, '{2, 5, 127, 1703}, '{2, 0, 0, 1000},
            '{3, 0, 63, 2063}, '{3, 1, 36, 2100}, '{3, 5, 127, 2703},
            '{4, 0, 0, 0}, '{4, 2, 10, -202}, '{4, 0, 63, -63}, '{4, 5, 127, -703},
            '{4, 0, 64, 0},
            '{5, 0, 63, 63}, '{5, 1, 0, 64}, '{5, 5, 127, 703}
        };
        model_clear();
        p_if.in_valid = 1'b0;
        p_if.para_in = '0;

        // reset state
        #2;
        chk("rst_in_ready", int'(p_if.in_ready), 1);
        chk("rst_load_done", int'(load_done), 0);
        chk("rst_swap_err", int'(swap_err), 0);
        cmp_bank("rst_active");
        mode_in = 1'b1;
        #1;
        chk("rst_in_ready_mode", int'(p_if.in_ready), 0);
        mode_in = 1'b0;
        #10;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // full load k, then commit
        load_words(0, NW, 0, 1, 1'b0);
        check_full("full");
        do_swap(1'b1);
        check_after_swap("full", 1);

        // second load with gaps and compute windows; active bank must hold
        load_words(0, NW / 2, 1000, 1, 1'b1);
        @(negedge clk);
        chk("dbuf_hold_mid", int'(para_out[3][5]), 325);
        @(posedge clk);
        #1;
        load_words(NW / 2, NW, 1000, 1, 1'b1);
        chk("no_accept_in_mode", stall_viol, 0);
        check_full("dbuf");
        do_swap(1'b1);
        check_after_swap("dbuf", 2);

        // premature swap after 100 words
        load_words(0, 100, 2000, 1, 1'b0);
        do_swap(1'b0);
        @(negedge clk);
        chk("early_swap_err_pulse", int'(swap_err), 1);
        chk("early_load_done", int'(load_done), 0);
        cmp_bank("early_active_kept");
        @(negedge clk);
        chk("early_swap_err_one_cycle", int'(swap_err), 0);
        @(posedge clk);
        #1;
        load_words(100, NW, 2000, 1, 1'b0);
        check_full("early");
        do_swap(1'b1);
        check_after_swap("early", 3);

        // restart mid-load; the word offered with restart must be refused
        load_words(0, 300, 5000, 1, 1'b0);
        restart = 1'b1;
        p_if.in_valid = 1'b1;
        p_if.para_in = PW'(7777);
        @(negedge clk);
        chk("restart_in_ready", int'(p_if.in_ready), 0);
        @(posedge clk);
        #1;
        restart = 1'b0;
        p_if.in_valid = 1'b0;
        mt = 0; mi = 0;
        load_words(0, NW, 0, -1, 1'b0);
        check_full("rst_reload");

        // restart together with swap in FULL: no commit, no error
        restart = 1'b1;
        swap = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        swap = 1'b0;
        mt = 0; mi = 0;
        @(negedge clk);
        chk("restart_swap_err", int'(swap_err), 0);
        chk("restart_swap_load_done", int'(load_done), 0);
        chk("restart_swap_in_ready", int'(p_if.in_ready), 1);
        cmp_bank("restart_swap_no_commit");
        @(posedge clk);
        #1;
        load_words(0, NW, 0, -1, 1'b0);
        check_full("neg");
        do_swap(1'b1);
        check_after_swap("neg", 4);

        // async reset at word 400
        load_words(0, 400, 0, 1, 1'b0);
        #2;
        rstn = 1'b0;
        model_clear();
        #1;
        cmp_bank("async_rst_active");
        chk("async_rst_load_done", int'(load_done), 0);
        chk("async_rst_swap_err", int'(swap_err), 0);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        load_words(0, NW, 0, 1, 1'b0);
        check_full("post_rst");
        do_swap(1'b1);
        check_after_swap("post_rst", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
